// File: rtl/debounce_pkg.sv
// Shared types and default constants for the sync_debounce block.
// Optional event counter is enabled by defining DEBOUNCE_EVENT_CNT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_debounce_if.sv
// Signal bundle between the debouncer and its consumer.
// Macro DEBOUNCE_EVENT_CNT_EN does not change this bundle.
interface sync_debounce_if #(
    parameter int CNT_W = debounce_pkg::DEF_CNT_W
);
    logic             din;
    logic             clr_cnt;
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] event_cnt;

    modport master (
        output din, clr_cnt,
        input  level, rise, fall, event_cnt
    );

    modport slave (
        input  din, clr_cnt,
        output level, rise, fall, event_cnt
    );
endinterface

// File: rtl/debounce_timer.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// Used by sync_debounce (macro DEBOUNCE_EVENT_CNT_EN has no effect here).
module debounce_timer #(
    parameter int STABLE_CYCLES = debounce_pkg::DEF_STABLE_CYCLES,
    localparam int W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count;

    // Count consecutive candidate samples; clear wins over enable, hold at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count: the current sample will be the last one needed.
    assign tc = (count == W'(STABLE_CYCLES - 1));
endmodule

// File: rtl/sync_debounce.sv
// Debouncer and edge detector for an already-synchronized level.
// Define DEBOUNCE_EVENT_CNT_EN to build the rising-event counter;
// otherwise event_cnt is tied to 0 and clr_cnt is ignored.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    sync_debounce_if.slave  bus
);
    state_t state;
    logic   level_q;
    logic   rise_q;
    logic   fall_q;
    logic   tmr_clr;
    logic   tmr_en;
    logic   tmr_tc;
    logic   accept_rise;

    debounce_timer #(.STABLE_CYCLES(STABLE_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc      (tmr_tc)
    );

    // Timer runs only while din disagrees with the accepted level and not yet accepted.
    always_comb begin
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        case (state)
            S_LOW:      if (bus.din)             begin tmr_clr = 1'b0; tmr_en = 1'b1; end
            S_RISE_CHK: if (bus.din && !tmr_tc)  begin tmr_clr = 1'b0; tmr_en = 1'b1; end
            S_HIGH:     if (!bus.din)            begin tmr_clr = 1'b0; tmr_en = 1'b1; end
            S_FALL_CHK: if (!bus.din && !tmr_tc) begin tmr_clr = 1'b0; tmr_en = 1'b1; end
            default: ;
        endcase
    end

    assign accept_rise = (state == S_RISE_CHK) && bus.din && tmr_tc;

    // Debounce FSM with registered level and one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_LOW;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                S_LOW: begin
                    if (bus.din) state <= S_RISE_CHK;
                end
                S_RISE_CHK: begin
                    if (!bus.din) begin
                        state <= S_LOW;
                    end else if (tmr_tc) begin
                        state   <= S_HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!bus.din) state <= S_FALL_CHK;
                end
                S_FALL_CHK: begin
                    if (bus.din) begin
                        state <= S_HIGH;
                    end else if (tmr_tc) begin
                        state   <= S_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count accepted rises; clear has priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.clr_cnt) begin
            cnt_q <= '0;
        end else if (accept_rise) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.event_cnt = cnt_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = bus.clr_cnt ^ accept_rise;
    assign bus.event_cnt     = '0;
`endif
endmodule

// File: tb/tb_sync_debounce.sv
// Directed self-checking bench for sync_debounce (STABLE_CYCLES=4).
// Works with DEBOUNCE_EVENT_CNT_EN defined or undefined.
module tb_sync_debounce;
    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic clr_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sync_debounce_if #(.CNT_W(8)) bus0 ();
    sync_debounce_if #(.CNT_W(2)) bus1 ();

    assign bus0.din     = din;
    assign bus0.clr_cnt = clr_cnt;
    assign bus1.din     = din;
    assign bus1.clr_cnt = 1'b0;

    sync_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    sync_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    function automatic int ec(input int v);
`ifdef DEBOUNCE_EVENT_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive din, let one rising edge pass, return at the following falling edge.
    task automatic cyc(input logic d);
        din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold din for n edges, checking that no pulse appears.
    task automatic hold_quiet(input logic d, input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            cyc(d);
            check("quiet_rise", 32'(bus0.rise), 0);
            check("quiet_fall", 32'(bus0.fall), 0);
            check("quiet_level", 32'(bus0.level), 32'(lvl));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        din     = 1'b1;
        clr_cnt = 1'b0;
        @(negedge clk);

        // 1: reset with din=1, then first rise
        cyc(1'b1);
        cyc(1'b1);
        check("rst_level", 32'(bus0.level), 0);
        check("rst_rise",  32'(bus0.rise), 0);
        check("rst_fall",  32'(bus0.fall), 0);
        check("rst_cnt",   32'(bus0.event_cnt), 0);
        reset_n = 1'b1;
        hold_quiet(1'b1, 3, 1'b0);
        cyc(1'b1);
        check("first_rise",  32'(bus0.rise), 1);
        check("first_level", 32'(bus0.level), 1);
        check("first_cnt",   32'(bus0.event_cnt), 32'(ec(1)));
        cyc(1'b1);
        check("first_rise_end", 32'(bus0.rise), 0);
        check("first_level_hold", 32'(bus0.level), 1);

        // 3: fall with a mid-check bounce restarting qualification
        hold_quiet(1'b0, 2, 1'b1);
        hold_quiet(1'b1, 1, 1'b1);
        hold_quiet(1'b0, 3, 1'b1);
        cyc(1'b0);
        check("fall_pulse", 32'(bus0.fall), 1);
        check("fall_rise",  32'(bus0.rise), 0);
        check("fall_level", 32'(bus0.level), 0);
        check("fall_cnt",   32'(bus0.event_cnt), 32'(ec(1)));
        cyc(1'b0);
        check("fall_pulse_end", 32'(bus0.fall), 0);

        // 2: glitch rejection
        hold_quiet(1'b1, 3, 1'b0);
        hold_quiet(1'b0, 1, 1'b0);
        hold_quiet(1'b1, 3, 1'b0);
        cyc(1'b1);
        check("glitch_rise",  32'(bus0.rise), 1);
        check("glitch_level", 32'(bus0.level), 1);
        check("glitch_cnt",   32'(bus0.event_cnt), 32'(ec(2)));
        hold_quiet(1'b0, 3, 1'b1);
        cyc(1'b0);
        check("glitch_fall", 32'(bus0.fall), 1);

        // bring counter to 5
        for (int p = 3; p <= 5; p++) begin
            hold_quiet(1'b1, 3, 1'b0);
            cyc(1'b1);
            check("press_rise", 32'(bus0.rise), 1);
            check("press_cnt",  32'(bus0.event_cnt), 32'(ec(p)));
            hold_quiet(1'b0, 3, 1'b1);
            cyc(1'b0);
            check("press_fall", 32'(bus0.fall), 1);
        end

        // 5: clear coincident with rise wins
        hold_quiet(1'b1, 3, 1'b0);
        clr_cnt = 1'b1;
        cyc(1'b1);
        clr_cnt = 1'b0;
        check("clr_rise",  32'(bus0.rise), 1);
        check("clr_cnt",   32'(bus0.event_cnt), 0);
        check("clr_other", 32'(bus1.event_cnt), 32'(ec(2)));
        hold_quiet(1'b0, 3, 1'b1);
        cyc(1'b0);
        check("clr_fall", 32'(bus0.fall), 1);

        // 6: reset in S_RISE_CHK with timer=2
        hold_quiet(1'b1, 2, 1'b0);
        reset_n = 1'b0;
        cyc(1'b1);
        check("midrst_level", 32'(bus0.level), 0);
        check("midrst_rise",  32'(bus0.rise), 0);
        check("midrst_cnt1",  32'(bus1.event_cnt), 0);
        cyc(1'b1);
        check("midrst_rise2", 32'(bus0.rise), 0);
        reset_n = 1'b1;
        hold_quiet(1'b0, 3, 1'b0);

        // 4: wrap on the 2-bit counter
        for (int p = 1; p <= 5; p++) begin
            hold_quiet(1'b1, 3, 1'b0);
            cyc(1'b1);
            check("wrap_rise", 32'(bus1.rise), 1);
            check("wrap_cnt",  32'(bus1.event_cnt), 32'(ec(p % 4)));
            check("wide_cnt",  32'(bus0.event_cnt), 32'(ec(p)));
            hold_quiet(1'b0, 3, 1'b1);
            cyc(1'b0);
            check("wrap_fall", 32'(bus1.fall), 1);
        end

        // standalone clear
        clr_cnt = 1'b1;
        cyc(1'b0);
        clr_cnt = 1'b0;
        check("clr_only", 32'(bus0.event_cnt), 0);
        check("clr_only_other", 32'(bus1.event_cnt), 32'(ec(1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_debounce.md
# sync_debounce

Debounces and edge-detects a single-bit level arriving from the two-flop synchronizer stage, which sits directly upstream. Produces a clean debounced level, single-cycle rise and fall pulses, and an optional count of qualified rising events. Typical use: DE10 push-buttons and slide switches after clock-domain synchronization, before control logic.

## Interface

- `STABLE_CYCLES`, default 16: consecutive identical samples required to accept a level change; legal range ≥ 2.
- `CNT_W`, default 8: width of the event counter.

- `clk` in 1: the only clock; all logic is rising-edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `din` in 1: level already synchronized into `clk` by the upstream synchronizer; not re-synchronized here.
- `clr_cnt` in 1: synchronous clear of `event_cnt`.
- `level` out 1: debounced level.
- `rise` out 1: one-cycle pulse on an accepted 0→1 change.
- `fall` out 1: one-cycle pulse on an accepted 1→0 change.
- `event_cnt` out `CNT_W`: number of accepted rises, modulo 2^`CNT_W`.

## Operation

- FSM states:
  - `S_LOW`: stable 0.
  - `S_RISE_CHK`: 0→1 candidate.
  - `S_HIGH`: stable 1.
  - `S_FALL_CHK`: 1→0 candidate.
- Timer width is `$clog2(STABLE_CYCLES+1)` and counts consecutive samples that differ from `level`.
- `S_LOW` behaviour:
  - `din=1` → `S_RISE_CHK`, timer=1.
  - Otherwise stay, timer=0.
- `S_RISE_CHK` behaviour:
  - `din=0` → `S_LOW`, timer=0. Any single-cycle glitch restarts qualification.
  - `din=1` and timer=`STABLE_CYCLES-1` → `S_HIGH`, timer=0, `level`←1, `rise`←1.
  - Otherwise timer+1.
- `S_HIGH` and `S_FALL_CHK` mirror the above with polarity inverted; acceptance sets `level`←0 and `fall`←1.
- `rise` and `fall` are registered. Each is high for exactly one cycle, coincident with the first cycle of the new `level`. They are never high together.
- `event_cnt` behaviour:
  - Increments by 1 in the cycle that `rise` is set.
  - Wraps from 2^`CNT_W`−1 to 0.
  - Falls do not count.
  - When `clr_cnt` coincides with an increment, `clr_cnt` wins and `event_cnt`=0.
- `reset_n` low at a rising edge sets the following values on that edge:
  - state=`S_LOW`, timer=0.
  - `level`=0, `rise`=0, `fall`=0, `event_cnt`=0.
- Reset overrides all other inputs.
- Reset mid-qualification abandons the candidate.
- If `din` is 1 when reset releases, a fresh rise is qualified from `S_LOW`.

## Timing

- Latency: `level` changes on the edge where `din` has been sampled at the new value on `STABLE_CYCLES` consecutive edges. With `STABLE_CYCLES`=4, `din` sampled 1 at edges k..k+3 gives `level`=1 and `rise`=1 after edge k+3.
- Total latency from the asynchronous pin is `STABLE_CYCLES` plus the 2-cycle synchronizer delay.
- Minimum spacing between accepted edges is `STABLE_CYCLES` cycles.
- No combinational path from any input to any output.

## Configuration

- Macro: `DEBOUNCE_EVENT_CNT_EN`.
- Defined: event counter and `clr_cnt` function as specified.
- Undefined:
  - No counter flops are built.
  - `event_cnt` is tied to 0.
  - `clr_cnt` is ignored.
  - Port list is unchanged.
  - `level`, `rise` and `fall` behaviour is identical.

## Structure

- Shared package `debounce_pkg` holds:
  - The FSM state enum typedef (`S_LOW`, `S_RISE_CHK`, `S_HIGH`, `S_FALL_CHK`).
  - The default constants for `STABLE_CYCLES` and `CNT_W`.
- One sub-module, `debounce_timer`, is natural: a parameterized saturating up-counter with sync clear and a terminal-count flag. The FSM drives its clear and enable.
- The synchronizer stays a separate upstream instance and is not absorbed into this block.

## Test plan

All scenarios use `STABLE_CYCLES`=4 and `CNT_W`=8 unless noted.

1. **Reset and first rise:** hold `reset_n`=0 with `din`=1 → all outputs 0. Release with `din` held at 1 → `rise`=1 for one cycle after the 4th sampling edge, `level`=1, `event_cnt`=1.
2. **Glitch rejection:** `din` 1 for 3 cycles, 0 for 1, 1 for 4 → no `rise` on the first burst; a single `rise` 4 edges into the second burst.
3. **Fall:** from `level`=1, drive `din`=0 for 4 cycles → one-cycle `fall`, `level`=0, `event_cnt` unchanged. A 1-cycle return to 1 mid-check restarts the count.
4. **Wrap:** `CNT_W`=2, five qualified presses → `event_cnt` reads 1, 2, 3, 0, 1.
5. **Clear priority:** `clr_cnt`=1 in the same cycle as `rise` with `event_cnt`=5 → `event_cnt`=0.
6. **Reset mid-check and build-time option:**
   - Assert `reset_n` low while in `S_RISE_CHK` with timer=2 → next cycle `level`=0, no pulse emitted.
   - Build with `DEBOUNCE_EVENT_CNT_EN` undefined → `event_cnt` is always 0 across scenario 1.
